interrupt_sequencer: RTL and testbench

//  Interrupt entry controller for the 5-stage pipeline. On an accepted interrupt it freezes fetch and drains
//  in-flight instructions. It then pushes resume PC (2 words) and CCR to the stack through the memory-stage

---
 rtl/interrupt_seq_pkg.sv | 26 ++
 rtl/interrupt_sequencer_if.sv | 23 ++
 rtl/interrupt_sequencer.sv | 160 ++++++++++++++++
 tb/tb_interrupt_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_seq_pkg.sv
// Shared types and constants for the interrupt entry sequencer.
package interrupt_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_PUSH_HI,
        ST_PUSH_LO,
        ST_PUSH_FL,
        ST_VEC_LO,
        ST_VEC_HI,
        ST_REDIRECT
    } seq_state_e;

    // Order in which words land on the stack
    localparam int PUSH_IDX_PC_HI = 0;
    localparam int PUSH_IDX_PC_LO = 1;
    localparam int PUSH_IDX_FLAGS = 2;
    localparam int PUSH_WORDS     = 3;

    localparam int CCR_W     = 4;
    localparam int CCR_PAD_W = 12;

    localparam logic [31:0] DEF_VECTOR_ADDR = 32'h0000_0000;

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Stack-push and vector-read ports between the sequencer (master) and the memory stage (slave).
interface interrupt_sequencer_if #(
    parameter int PC_W   = 32,
    parameter int DATA_W = 16
);
    logic              push_valid;
    logic              push_ready;
    logic [DATA_W-1:0] push_data;
    logic              vec_rd;
    logic [PC_W-1:0]   vec_addr;
    logic              vec_valid;
    logic [DATA_W-1:0] vec_data;

    modport master (
        output push_valid, push_data, vec_rd, vec_addr,
        input  push_ready, vec_valid, vec_data
    );

    modport slave (
        input  push_valid, push_data, vec_rd, vec_addr,
        output push_ready, vec_valid, vec_data
    );
endinterface

// File: rtl/interrupt_sequencer.sv
// Interrupt entry: drain pipeline, push PC/CCR, fetch handler vector, redirect fetch.
// Optional INTERRUPT_SEQ_PENDING_LATCH_EN keeps a request that rises while busy.
module interrupt_sequencer
    import interrupt_seq_pkg::*;
#(
    parameter int              PC_W         = 32,
    parameter int              DATA_W       = 16,
    parameter int              DRAIN_CYCLES = 3,
    parameter logic [PC_W-1:0] VECTOR_ADDR  = PC_W'(DEF_VECTOR_ADDR)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             interrupt,
    input  logic             flush_in,
    input  logic             two_word_in_decode,
    input  logic [PC_W-1:0]  pc_resume,
    input  logic [CCR_W-1:0] flags_in,
    output logic             stall_fetch,
    output logic             bubble,
    output logic             flags_save,
    output logic             pc_load,
    output logic [PC_W-1:0]  pc_load_value,
    output logic             int_ack,
    output logic             busy,
    interrupt_sequencer_if.master mem
);

    localparam int             CNT_W      = $clog2(DRAIN_CYCLES) + 1;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    seq_state_e        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [PC_W-1:0]   pc_cap;
    logic [CCR_W-1:0]  flags_cap;
    logic [DATA_W-1:0] vec_lo, vec_hi;
    logic              flags_save_q;
    logic              req;
    logic              accept;

    logic              push_valid_c;
    logic [DATA_W-1:0] push_data_c;
    logic              vec_rd_c;
    logic [PC_W-1:0]   vec_addr_c;

`ifdef INTERRUPT_SEQ_PENDING_LATCH_EN
    logic int_q;
    logic pending;

    // A rising edge seen while busy is remembered and served as a level request once idle
    always_ff @(posedge clk) begin
        if (reset) begin
            int_q   <= 1'b0;
            pending <= 1'b0;
        end else begin
            int_q <= interrupt;
            if (accept)
                pending <= 1'b0;
            else if (interrupt && !int_q && state != ST_IDLE)
                pending <= 1'b1;
        end
    end

    assign req = interrupt | pending;
`else
    assign req = interrupt;
`endif

    assign accept = (state == ST_IDLE) && req && !flush_in && !two_word_in_decode;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (accept)              state_nxt = ST_DRAIN;
            ST_DRAIN:    if (cnt == DRAIN_LAST)   state_nxt = ST_PUSH_HI;
            ST_PUSH_HI:  if (mem.push_ready)      state_nxt = ST_PUSH_LO;
            ST_PUSH_LO:  if (mem.push_ready)      state_nxt = ST_PUSH_FL;
            ST_PUSH_FL:  if (mem.push_ready)      state_nxt = ST_VEC_LO;
            ST_VEC_LO:   if (mem.vec_valid)       state_nxt = ST_VEC_HI;
            ST_VEC_HI:   if (mem.vec_valid)       state_nxt = ST_REDIRECT;
            ST_REDIRECT:                          state_nxt = ST_IDLE;
            default:                              state_nxt = ST_IDLE;
        endcase
    end

    // flags_save is registered so it stays low while reset is held, whatever interrupt does
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            pc_cap       <= '0;
            flags_cap    <= '0;
            vec_lo       <= '0;
            vec_hi       <= '0;
            flags_save_q <= 1'b0;
        end else begin
            flags_save_q <= accept;
            if (accept) begin
                cnt       <= '0;
                pc_cap    <= pc_resume;
                flags_cap <= flags_in;
            end else if (state == ST_DRAIN) begin
                cnt <= cnt + 1'b1;
            end
            if (state == ST_VEC_LO && mem.vec_valid) vec_lo <= mem.vec_data;
            if (state == ST_VEC_HI && mem.vec_valid) vec_hi <= mem.vec_data;
        end
    end

    always_comb begin
        stall_fetch   = (state != ST_IDLE);
        busy          = (state != ST_IDLE);
        bubble        = (state == ST_DRAIN);
        flags_save    = flags_save_q;
        pc_load       = 1'b0;
        int_ack       = 1'b0;
        pc_load_value = '0;
        push_valid_c  = 1'b0;
        push_data_c   = '0;
        vec_rd_c      = 1'b0;
        vec_addr_c    = '0;
        case (state)
            ST_PUSH_HI: begin
                push_valid_c = 1'b1;
                push_data_c  = pc_cap[PC_W-1 -: DATA_W];
            end
            ST_PUSH_LO: begin
                push_valid_c = 1'b1;
                push_data_c  = pc_cap[DATA_W-1:0];
            end
            ST_PUSH_FL: begin
                push_valid_c = 1'b1;
                push_data_c  = DATA_W'({{CCR_PAD_W{1'b0}}, flags_cap});
            end
            ST_VEC_LO: begin
                vec_rd_c   = 1'b1;
                vec_addr_c = VECTOR_ADDR;
            end
            ST_VEC_HI: begin
                vec_rd_c   = 1'b1;
                vec_addr_c = VECTOR_ADDR + 1'b1;
            end
            ST_REDIRECT: begin
                pc_load       = 1'b1;
                int_ack       = 1'b1;
                pc_load_value = PC_W'({vec_hi, vec_lo});
            end
            default: ;
        endcase
    end

    assign mem.push_valid = push_valid_c;
    assign mem.push_data  = push_data_c;
    assign mem.vec_rd     = vec_rd_c;
    assign mem.vec_addr   = vec_addr_c;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Randomized bench for interrupt_sequencer against a transaction-level model of the entry sequence.
module tb_interrupt_sequencer;
    import interrupt_seq_pkg::*;

    localparam int          DRAIN = 3;
    localparam logic [31:0] VADDR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, interrupt, flush_in, two_word_in_decode;
    logic [31:0] pc_resume;
    logic [3:0]  flags_in;
    logic        stall_fetch, bubble, flags_save, pc_load, int_ack, busy;
    logic [31:0] pc_load_value;

    int n_chk  = 0;
    int n_fail = 0;

    interrupt_sequencer_if #(.PC_W(32), .DATA_W(16)) mem_if ();

    interrupt_sequencer #(
        .PC_W(32), .DATA_W(16), .DRAIN_CYCLES(DRAIN), .VECTOR_ADDR(VADDR)
    ) dut (
        .clk(clk), .reset(reset), .interrupt(interrupt), .flush_in(flush_in),
        .two_word_in_decode(two_word_in_decode), .pc_resume(pc_resume), .flags_in(flags_in),
        .stall_fetch(stall_fetch), .bubble(bubble), .flags_save(flags_save),
        .pc_load(pc_load), .pc_load_value(pc_load_value), .int_ack(int_ack), .busy(busy),
        .mem(mem_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] all_outs();
        return {stall_fetch, bubble, flags_save, busy, mem_if.push_valid, mem_if.push_data,
                mem_if.vec_rd, mem_if.vec_addr, pc_load, pc_load_value, int_ack};
    endfunction

    function automatic logic [7:0] ctl();
        return {stall_fetch, bubble, flags_save, busy, mem_if.push_valid, mem_if.vec_rd, pc_load, int_ack};
    endfunction

    // Called #1 after a rising edge with the DUT idle; returns the same way.
    // bp: 0 zero-wait, 1 push_ready low 2 cycles in PUSH_LO, 2 random waits.
    task automatic run_entry(input logic [31:0] pc, input logic [3:0] fl,
                             input logic [15:0] vlo, input logic [15:0] vhi,
                             input int bp, input int defer, input int dmode,
                             input int abort_lo, input int second_int, input int exp_r);
        logic [15:0] words [3];
        int np = 0, nv = 0, waits = 0, lo_hold = 0, r_seen = -1, g;
        bit fired = 0, aborted = 0, done = 0, pr, vv, exp_bub, exp_pv, exp_vr, exp_pl;
        words[0] = pc[31:16];
        words[1] = pc[15:0];
        words[2] = {12'h000, fl};

        for (int d = 0; d < defer; d++) begin
            interrupt = 1'b1;
            if (dmode == 1) begin
                flush_in = (d < 2);
                two_word_in_decode = (d == 2);
            end else begin
                g = $urandom_range(1, 3);
                flush_in = g[0];
                two_word_in_decode = g[1];
            end
            pc_resume = $urandom;
            flags_in  = 4'($urandom);
            @(negedge clk);
            chk("defer_busy", busy, 0);
            tick();
        end

        interrupt = 1'b1;
        flush_in = 1'b0;
        two_word_in_decode = 1'b0;
        reset = 1'b0;
        pc_resume = pc;
        flags_in = fl;
        @(negedge clk);
        chk("pre_accept_busy", busy, 0);
        tick();

        for (int r = 1; r <= 60; r++) begin
            interrupt = 1'b0;
            pc_resume = $urandom;
            flags_in  = 4'($urandom);
            if (second_int != 0 && !fired && np == 0 && r > DRAIN) begin
                interrupt = 1'b1;
                fired = 1;
            end
            case (bp)
                0: begin pr = 1; vv = 1; end
                1: begin
                    pr = !(np == 1 && lo_hold < 2);
                    if (!pr) lo_hold++;
                    vv = 1;
                end
                default: begin
                    pr = ($urandom_range(0, 3) != 0);
                    vv = ($urandom_range(0, 3) != 0);
                end
            endcase
            mem_if.push_ready = pr;
            mem_if.vec_valid  = vv;
            mem_if.vec_data   = vv ? ((nv == 0) ? vlo : vhi) : 16'($urandom);
            if (abort_lo != 0 && np == 1) reset = 1'b1;
            @(negedge clk);
            exp_bub = (r <= DRAIN);
            exp_pv  = (r > DRAIN) && (np < 3);
            exp_vr  = (np == 3) && (nv < 2);
            exp_pl  = (np == 3) && (nv == 2);
            chk("ctl", ctl(), {1'b1, exp_bub, (r == 1), 1'b1, exp_pv, exp_vr, exp_pl, exp_pl});
            if (exp_pv) chk("push_data", mem_if.push_data, words[np]);
            if (exp_vr) chk("vec_addr", mem_if.vec_addr, VADDR + nv);
            if (exp_pl) chk("pc_load_value", pc_load_value, {vhi, vlo});
            if (pc_load && r_seen < 0) r_seen = r;
            if (reset) begin aborted = 1; break; end
            if (exp_pv) begin if (pr) np++; else waits++; end
            if (exp_vr) begin if (vv) nv++; else waits++; end
            if (exp_pl) begin done = 1; break; end
            tick();
        end
        mem_if.push_ready = 1'b1;
        mem_if.vec_valid  = 1'b1;
        interrupt = 1'b0;

        if (aborted) begin
            tick();
            reset = 1'b0;
            @(negedge clk);
            chk("abort_outs", all_outs(), 0);
            for (int i = 0; i < 12; i++) begin
                tick();
                @(negedge clk);
                chk("abort_quiet", {busy, pc_load, int_ack}, 0);
            end
            tick();
        end else begin
            chk("entry_done", done, 1);
            chk("pc_load_cycle", r_seen, (exp_r < 0) ? (DRAIN + 6 + waits) : exp_r);
            tick();
            @(negedge clk);
            chk("post_idle", {busy, pc_load, int_ack}, 0);
            if (second_int != 0) begin
`ifdef INTERRUPT_SEQ_PENDING_LATCH_EN
                tick();
                @(negedge clk);
                chk("pend_drain", {busy, bubble}, 2'b11);
                r_seen = -1;
                for (int i = 0; i < 40 && r_seen < 0; i++) begin
                    tick();
                    @(negedge clk);
                    if (pc_load) r_seen = i;
                end
                chk("pend_done", (r_seen >= 0), 1);
                tick();
                @(negedge clk);
                chk("pend_idle", busy, 0);
`else
                for (int i = 0; i < 3; i++) begin
                    tick();
                    @(negedge clk);
                    chk("no_pend", busy, 0);
                end
`endif
            end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        interrupt = 1'b1;
        flush_in = 1'b0;
        two_word_in_decode = 1'b0;
        pc_resume = '0;
        flags_in = '0;
        mem_if.push_ready = 1'b0;
        mem_if.vec_valid  = 1'b0;
        mem_if.vec_data   = '0;

        tick();
        @(negedge clk);
        chk("rst_outs0", all_outs(), 0);
        tick();
        @(negedge clk);
        chk("rst_outs1", all_outs(), 0);
        tick();

        // reset drops with interrupt still high, then the basic zero-wait entry
        run_entry(32'h0000_0123, 4'hA, 16'h0040, 16'h0000, 0, 0, 0, 0, 0, 9);
        run_entry(32'h0000_0123, 4'hA, 16'h0040, 16'h0000, 1, 0, 0, 0, 0, 11);
        run_entry(32'hDEAD_BEEF, 4'h5, 16'h1234, 16'h8000, 0, 3, 1, 0, 0, 9);
        run_entry(32'h1357_9BDF, 4'hF, 16'hAAAA, 16'h5555, 0, 0, 0, 1, 0, -1);
        run_entry(32'h0BAD_F00D, 4'h3, 16'h0100, 16'h0002, 0, 0, 0, 0, 1, 9);

        for (int k = 0; k < 20; k++) begin
            run_entry($urandom, 4'($urandom), 16'($urandom), 16'($urandom),
                      $urandom_range(0, 2), $urandom_range(0, 3), 0, 0,
                      ($urandom_range(0, 3) == 0) ? 1 : 0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
